lsq_commit_queue: RTL and testbench
===================================

// Module: lsq_commit_queue
// PURPOSE
//  Parametrised in-order load/store queue between the LSB reservation station, the memory
//  controller, the ROB and the CDB. Computes addresses at enqueue and issues one memory
//  transaction at a time from the head.
//  Non-I/O loads issue speculatively, without waiting for commit. Stores and I/O loads
//  issue only once the ROB has committed them.
//  A flush (clear) drops only uncommitted entries. Committed stores survive and drain.
// PARAMETERS
//  DEPTH    16           entries; power of two, >=4
//  TAG_W    4            CDB/ROB tag width
//  SLACK    2            full asserts when free entries <= SLACK (in-flight dispatch margin)
//  IO_BASE  32'h00030000 loads with addr >= IO_BASE are I/O; they wait for commit
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active-low
//  clear        in   1      sync flush from ROB (mispredict)
//  in_valid     in   1      enqueue one entry this cycle
//  in_is_store  in   1      1=store, 0=load
//  in_funct3    in   3      RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  in_base      in   32     rs1 value
//  in_imm       in   32     sign-extended offset
//  in_sdata     in   32     store data (rs2)
//  in_tag       in   TAG_W  destination ROB tag
//  full         out  1      back-pressure to LSB RS
//  rob_commit   in   1      ROB committed the oldest not-yet-committed LS instr (program order)
//  mem_req      out  1      transaction request, held until mem_done
//  mem_we       out  1      1=write
//  mem_addr     out  32     byte address
//  mem_len      out  3      001 byte, 010 half, 100 word
//  mem_wdata    out  32     write data, zero-extended to the access size
//  mem_done     in   1      1-cycle pulse: transaction complete; read data valid this cycle
//  mem_rdata    in   32     read data, low bytes
//  cdb_valid    out  1      1-cycle broadcast
//  cdb_tag      out  TAG_W
//  cdb_data     out  32
// BEHAVIOUR
//  Reset (rst=0, async): head=tail=0, count=0, credit=0, state=IDLE.
//   All outputs 0 except full=0.
//  Storage: ring of DEPTH entries; head/tail wrap DEPTH-1 -> 0; count tracked explicitly.
//   Full (count=DEPTH) and empty (count=0) are distinguished by count, not by pointer compare.
//  Enqueue: on in_valid, store addr=in_base+in_imm (mod 2^32), op, tag and data at tail.
//   tail++, count++. in_valid while count=DEPTH is a protocol error; the entry is dropped.
//  full = (DEPTH-count) <= SLACK; it is combinational from count.
//  credit: signed counter, log2(DEPTH)+2 bits. +1 on rob_commit, -1 on pop; both in the
//   same cycle => net 0. Head is committed iff credit > 0.
//  Issue condition (state IDLE, count>0, not clear):
//   head is a non-I/O load, OR head is committed (credit>0).
//  FSM:
//   IDLE -> BUSY when the issue condition holds. mem_req, mem_we, mem_addr, mem_len and
//    mem_wdata are registered next edge, then stay stable in BUSY.
//   BUSY -> IDLE on mem_done: pop head (head++, count--, credit--), drop mem_req the same
//    edge. Next issue is no earlier than the following cycle.
//   Entry to FSM cycle latency >= 1; mem_done to cdb_valid = 1 cycle.
//  CDB, driven on the edge after mem_done, with cdb_tag = head tag:
//   B: sign-extend [7:0]. H: sign-extend [15:0]. W: full word.
//   BU: zero-extend [7:0]. HU: zero-extend [15:0].
//   Stores also broadcast (cdb_data=0) to mark completion.
//   cdb_valid is low in every other cycle.
//  Enqueue and pop in the same cycle: count unchanged; both pointers advance.
//  clear:
//   keep = max(credit,0) entries from head (committed, not yet done).
//   tail = head+keep (mod DEPTH), count = keep, credit = keep.
//   Same-cycle in_valid and rob_commit are ignored.
//  clear while BUSY:
//   The transaction completes; memory is never aborted.
//   Head committed => normal pop and CDB broadcast.
//   Head uncommitted (speculative load) => go to DRAIN: wait for mem_done, then return to
//    IDLE. No pop, no CDB broadcast, since that entry was already discarded.
//   state = IDLE | BUSY | DRAIN.
//  Loads never bypass older stores: strictly in-order issue, no forwarding.
// TESTING
//  T1 reset: rst low mid-BUSY -> all outputs 0 immediately, count=0, full=0.
//  T2 speculative load: LW base=0x100, imm=4, no commit.
//   -> mem_req, addr 0x104, len 100.
//   -> mem_done with rdata 0xDEADBEEF -> next cycle cdb_valid=1, data 0xDEADBEEF.
//  T3 store gating: SH data 0x1234ABCD enqueued -> no mem_req for 10 cycles.
//   -> rob_commit -> mem_req, we=1, len 010, wdata 0x0000ABCD.
//  T4 I/O load: LB addr 0x30000 waits for commit.
//   After commit, rdata 0x80 -> cdb_data 0xFFFFFF80. LBU gives 0x80. LHU 0x8001 gives 0x8001.
//  T5 flush: enqueue SW(committed), LW, SB.
//   clear -> count=1, only SW issues. Clear during a speculative LW in BUSY
//   -> DRAIN, no cdb_valid.
//  T6 wrap/full: DEPTH=4, SLACK=2.
//   full rises at count=2. 20 enqueue/pop pairs exercise wrap.
//   Simultaneous enqueue+pop keeps count; order of CDB tags matches enqueue order.

Source files
------------

// File: rtl/lsq_commit_queue.sv
// lsq_commit_queue: in-order load/store queue; speculative non-I/O loads, commit-gated stores and I/O loads
// Ports: clk, rst (async, active-low); clear = mispredict flush from ROB;
//        in_* = enqueue from LSB RS, full = back-pressure (free entries <= SLACK);
//        rob_commit = oldest uncommitted LS instruction committed;
//        mem_* = single outstanding memory transaction from the head;
//        cdb_* = one-cycle result broadcast (stores broadcast zero).
module lsq_commit_queue #(
    parameter int          DEPTH   = 16,
    parameter int          TAG_W   = 4,
    parameter int          SLACK   = 2,
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_is_store,
    input  logic [2:0]       in_funct3,
    input  logic [31:0]      in_base,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_sdata,
    input  logic [TAG_W-1:0] in_tag,
    output logic             full,
    input  logic             rob_commit,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [2:0]       mem_len,
    output logic [31:0]      mem_wdata,
    input  logic             mem_done,
    input  logic [31:0]      mem_rdata,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_data
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW-1:0]        ptr_t;
    typedef logic [AW:0]          cnt_t;
    typedef logic signed [AW+1:0] crd_t;
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    logic [31:0]      r_addr  [DEPTH];
    logic [31:0]      r_sdata [DEPTH];
    logic             r_st    [DEPTH];
    logic [2:0]       r_f3    [DEPTH];
    logic [TAG_W-1:0] r_tag   [DEPTH];
    state_t           r_state;
    ptr_t             r_head, r_tail;
    cnt_t             r_count;
    // Commits seen minus entries popped; goes negative while completed speculative loads await commit.
    crd_t             r_credit;

    logic             w_st, w_io, w_cmt, w_enq, w_issue, w_pop;
    logic [2:0]       w_f3, w_len;
    logic [31:0]      w_addr, w_sdata, w_wdata, w_ext;
    logic [TAG_W-1:0] w_tag;
    crd_t             w_keep;

    assign w_st    = r_st[r_head];
    assign w_f3    = r_f3[r_head];
    assign w_addr  = r_addr[r_head];
    assign w_sdata = r_sdata[r_head];
    assign w_tag   = r_tag[r_head];
    assign w_io    = !w_st && (w_addr >= IO_BASE);
    assign w_cmt   = !r_credit[AW+1] && (r_credit != '0);
    assign w_keep  = w_cmt ? r_credit : '0;
    assign full    = r_count >= cnt_t'(DEPTH - SLACK);
    assign w_enq   = in_valid && !clear && (r_count != cnt_t'(DEPTH));
    assign w_issue = (r_state == IDLE) && (r_count != '0) && !clear && ((!w_st && !w_io) || w_cmt);
    // A flushed speculative head still completes in memory but is neither popped nor broadcast.
    assign w_pop   = (r_state == BUSY) && mem_done && (!clear || w_cmt);
    assign w_len   = w_f3[1:0] == 2'b00 ? 3'b001 : w_f3[1:0] == 2'b01 ? 3'b010 : 3'b100;
    assign w_wdata = w_f3[1:0] == 2'b00 ? {24'b0, w_sdata[7:0]} :
                     w_f3[1:0] == 2'b01 ? {16'b0, w_sdata[15:0]} : w_sdata;
    // funct3[2] selects the unsigned variants, which suppress the sign fill.
    assign w_ext   = w_f3[1:0] == 2'b00 ? {{24{!w_f3[2] && mem_rdata[7]}}, mem_rdata[7:0]} :
                     w_f3[1:0] == 2'b01 ? {{16{!w_f3[2] && mem_rdata[15]}}, mem_rdata[15:0]} : mem_rdata;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail]  <= in_base + in_imm;
            r_sdata[r_tail] <= in_sdata;
            r_st[r_tail]    <= in_is_store;
            r_f3[r_tail]    <= in_funct3;
            r_tag[r_tail]   <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_credit  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_len   <= '0;
            mem_wdata <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else begin
            r_head    <= r_head + ptr_t'(w_pop);
            r_tail    <= clear ? r_head + ptr_t'(w_keep) : r_tail + ptr_t'(w_enq);
            r_count   <= clear ? cnt_t'(w_keep) - cnt_t'(w_pop) : r_count + cnt_t'(w_enq) - cnt_t'(w_pop);
            r_credit  <= clear ? w_keep - crd_t'(w_pop) : r_credit + crd_t'(rob_commit) - crd_t'(w_pop);
            cdb_valid <= w_pop;
            cdb_tag   <= w_pop ? w_tag : '0;
            cdb_data  <= (w_pop && !w_st) ? w_ext : '0;
            if (w_issue) begin
                r_state   <= BUSY;
                mem_req   <= 1'b1;
                mem_we    <= w_st;
                mem_addr  <= w_addr;
                mem_len   <= w_len;
                mem_wdata <= w_st ? w_wdata : '0;
            end else if (r_state != IDLE && mem_done) begin
                r_state   <= IDLE;
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_len   <= '0;
                mem_wdata <= '0;
            end else if (r_state == BUSY && clear && !w_cmt) begin
                r_state   <= DRAIN;
            end
        end
    end
endmodule

// File: tb/tb_lsq_commit_queue.sv
// tb_lsq_commit_queue: directed scenarios plus a randomized run against a queue-based reference model
module tb_lsq_commit_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0, in_valid = 1'b0, in_is_store = 1'b0, rob_commit = 1'b0, mem_done = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_base = '0, in_imm = '0, in_sdata = '0, mem_rdata = '0;
    logic [3:0]  in_tag = '0;
    logic        full, mem_req, mem_we, cdb_valid;
    logic [31:0] mem_addr, mem_wdata, cdb_data;
    logic [2:0]  mem_len;
    logic [3:0]  cdb_tag;
    int errors = 0;
    int checks = 0;

    lsq_commit_queue #(.DEPTH(4), .TAG_W(4), .SLACK(2)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_base(in_base), .in_imm(in_imm), .in_sdata(in_sdata), .in_tag(in_tag),
        .full(full), .rob_commit(rob_commit), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_len(mem_len), .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  tag;
    } ent_t;

    function automatic logic [31:0] ext_of(input logic [2:0] f3, input logic [31:0] r);
        case (f3)
            3'b000:  return {{24{r[7]}}, r[7:0]};
            3'b001:  return {{16{r[15]}}, r[15:0]};
            3'b100:  return r & 32'h0000_00FF;
            3'b101:  return r & 32'h0000_FFFF;
            default: return r;
        endcase
    endfunction

    function automatic logic [2:0] len_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 3'b001;
            3'b001, 3'b101: return 3'b010;
            default:        return 3'b100;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] d);
        case (len_of(f3))
            3'b001:  return d % 256;
            3'b010:  return d % 65536;
            default: return d;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear = 1'b0; in_valid = 1'b0; rob_commit = 1'b0; mem_done = 1'b0; mem_rdata = '0;
        in_is_store = 1'b0; in_funct3 = '0; in_base = '0; in_imm = '0; in_sdata = '0; in_tag = '0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic enq(input bit st, input logic [2:0] f3, input logic [31:0] base, input logic [31:0] imm,
                       input logic [31:0] data, input logic [3:0] tag);
        in_valid = 1'b1; in_is_store = st; in_funct3 = f3; in_base = base; in_imm = imm;
        in_sdata = data; in_tag = tag;
        step();
        in_valid = 1'b0;
    endtask

    task automatic commit();
        rob_commit = 1'b1;
        step();
        rob_commit = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd);
        mem_done = 1'b1;
        mem_rdata = rd;
        step();
        mem_done = 1'b0;
    endtask

    task automatic wait_req(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (mem_req === 1'b1) ok = 1'b1;
    endtask

    task automatic test_reset();
        bit ok;
        bit seen;
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_len, mem_wdata, cdb_valid, cdb_tag, cdb_data, full} !== '0) begin
            errors++;
            $display("FAIL reset_state: got req=%b addr=%h cdb=%b full=%b required all zero", mem_req, mem_addr, cdb_valid, full);
        end
        step();
        rst = 1'b1;
        step();
        enq(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 4'h1);
        wait_req(4, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t1_busy: got mem_req=%b required 1", mem_req); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_len, mem_wdata, cdb_valid, cdb_tag, cdb_data} !== '0) begin
            errors++;
            $display("FAIL t1_async_reset: got req=%b addr=%h len=%b required all zero", mem_req, mem_addr, mem_len);
        end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL t1_full: got %b required 0", full); end
        #1 rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (mem_req !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL t1_queue_empty: got reissue after reset required none"); end
    endtask

    task automatic test_spec_load();
        bit ok;
        do_reset();
        enq(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 4'h1);
        wait_req(4, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t2_req: got mem_req=%b required 1", mem_req); end
        checks++;
        if ({mem_we, mem_addr, mem_len} !== {1'b0, 32'h104, 3'b100}) begin
            errors++;
            $display("FAIL t2_txn: got we=%b addr=%h len=%b required we=0 addr=00000104 len=100", mem_we, mem_addr, mem_len);
        end
        respond(32'hDEAD_BEEF);
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, mem_req} !== {1'b1, 4'h1, 32'hDEAD_BEEF, 1'b0}) begin
            errors++;
            $display("FAIL t2_cdb: got v=%b tag=%h data=%h req=%b required v=1 tag=1 data=deadbeef req=0", cdb_valid, cdb_tag, cdb_data, mem_req);
        end
        step();
        checks++;
        if (cdb_valid !== 1'b0) begin errors++; $display("FAIL t2_cdb_pulse: got %b required 0", cdb_valid); end
    endtask

    task automatic test_store_gate();
        bit ok;
        bit seen;
        do_reset();
        enq(1'b1, 3'b001, 32'h200, 32'h10, 32'h1234_ABCD, 4'h2);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req !== 1'b0) seen = 1'b1;
            step();
        end
        checks++;
        if (seen) begin errors++; $display("FAIL t3_gated: got mem_req before commit required none"); end
        commit();
        wait_req(4, ok);
        checks++;
        if (!ok || {mem_we, mem_addr, mem_len, mem_wdata} !== {1'b1, 32'h210, 3'b010, 32'h0000_ABCD}) begin
            errors++;
            $display("FAIL t3_store: got req=%b we=%b addr=%h len=%b wdata=%h required 1 1 00000210 010 0000abcd", mem_req, mem_we, mem_addr, mem_len, mem_wdata);
        end
        respond($urandom);
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'h2, 32'h0}) begin
            errors++;
            $display("FAIL t3_cdb: got v=%b tag=%h data=%h required v=1 tag=2 data=0", cdb_valid, cdb_tag, cdb_data);
        end
    endtask

    task automatic test_io_load();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b101, 3'b001};
        logic [31:0] rds [4] = '{32'h80, 32'h80, 32'h8001, 32'h8001};
        logic [31:0] exs [4] = '{32'hFFFF_FF80, 32'h80, 32'h8001, 32'hFFFF_8001};
        bit ok;
        bit seen;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            enq(1'b0, f3s[i], 32'h3_0000, 32'h0, 32'h0, 4'(i + 8));
            seen = 1'b0;
            for (int j = 0; j < 5; j++) begin
                if (mem_req !== 1'b0) seen = 1'b1;
                step();
            end
            checks++;
            if (seen) begin errors++; $display("FAIL t4_io_gated[%0d]: got mem_req before commit required none", i); end
            commit();
            wait_req(4, ok);
            checks++;
            if (!ok || {mem_we, mem_addr, mem_len} !== {1'b0, 32'h3_0000, len_of(f3s[i])}) begin
                errors++;
                $display("FAIL t4_io_txn[%0d]: got req=%b addr=%h len=%b required addr=00030000", i, mem_req, mem_addr, mem_len);
            end
            respond(rds[i]);
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'(i + 8), exs[i]}) begin
                errors++;
                $display("FAIL t4_io_cdb[%0d]: got v=%b tag=%h data=%h required data=%h", i, cdb_valid, cdb_tag, cdb_data, exs[i]);
            end
        end
        // Just below IO_BASE: an ordinary load, issues speculatively.
        enq(1'b0, 3'b010, 32'h3_0000, 32'hFFFF_FFFC, 32'h0, 4'hC);
        wait_req(3, ok);
        checks++;
        if (!ok || mem_addr !== 32'h2_FFFC) begin
            errors++;
            $display("FAIL t4_below_io: got req=%b addr=%h required req=1 addr=0002fffc", mem_req, mem_addr);
        end
        respond(32'h5);
    endtask

    task automatic test_flush();
        bit ok;
        bit seen;
        do_reset();
        enq(1'b1, 3'b010, 32'h400, 32'h0, 32'hCAFE_F00D, 4'h4);
        enq(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 4'h5);
        enq(1'b1, 3'b000, 32'h600, 32'h0, 32'h77, 4'h6);
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL t5_full_before: got %b required 1", full); end
        commit();
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL t5_full_after: got %b required 0", full); end
        wait_req(4, ok);
        checks++;
        if (!ok || {mem_we, mem_addr, mem_len, mem_wdata} !== {1'b1, 32'h400, 3'b100, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL t5_sw: got req=%b we=%b addr=%h wdata=%h required store to 00000400", mem_req, mem_we, mem_addr, mem_wdata);
        end
        respond(32'h0);
        checks++;
        if ({cdb_valid, cdb_tag} !== {1'b1, 4'h4}) begin
            errors++;
            $display("FAIL t5_sw_cdb: got v=%b tag=%h required v=1 tag=4", cdb_valid, cdb_tag);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_req !== 1'b0 || cdb_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL t5_flushed: got activity from flushed entries required none"); end
        enq(1'b0, 3'b010, 32'h700, 32'h0, 32'h0, 4'h7);
        wait_req(4, ok);
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if ({ok, mem_req, mem_addr} !== {1'b1, 1'b1, 32'h700}) begin
            errors++;
            $display("FAIL t5_drain_hold: got req=%b addr=%h required req=1 addr=00000700", mem_req, mem_addr);
        end
        enq(1'b0, 3'b010, 32'h800, 32'h0, 32'h0, 4'h8);
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h700}) begin
            errors++;
            $display("FAIL t5_drain_noissue: got req=%b addr=%h required req=1 addr=00000700", mem_req, mem_addr);
        end
        respond(32'h1111_2222);
        checks++;
        if ({cdb_valid, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL t5_drain_cdb: got v=%b req=%b required v=0 req=0", cdb_valid, mem_req);
        end
        wait_req(4, ok);
        checks++;
        if (!ok || mem_addr !== 32'h800) begin
            errors++;
            $display("FAIL t5_after_drain: got req=%b addr=%h required req=1 addr=00000800", mem_req, mem_addr);
        end
        respond(32'h3333_4444);
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'h8, 32'h3333_4444}) begin
            errors++;
            $display("FAIL t5_after_drain_cdb: got v=%b tag=%h data=%h required v=1 tag=8 data=33334444", cdb_valid, cdb_tag, cdb_data);
        end
    endtask

    task automatic test_wrap_full();
        bit ok;
        logic [31:0] rd;
        do_reset();
        enq(1'b1, 3'b010, 32'h900, 32'h0, 32'h0, 4'h1);
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL t6_full_1: got %b required 0", full); end
        enq(1'b1, 3'b010, 32'h904, 32'h0, 32'h0, 4'h2);
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL t6_full_2: got %b required 1", full); end
        do_reset();
        enq(1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 4'h0);
        enq(1'b0, 3'b010, 32'h1004, 32'h0, 32'h0, 4'h1);
        for (int i = 0; i < 22; i++) begin
            wait_req(3, ok);
            checks++;
            if (!ok || mem_addr !== 32'h1000 + 32'(4 * i)) begin
                errors++;
                $display("FAIL t6_addr[%0d]: got req=%b addr=%h required %h", i, mem_req, mem_addr, 32'h1000 + 32'(4 * i));
            end
            rd = $urandom;
            mem_done = 1'b1; mem_rdata = rd; rob_commit = 1'b1;
            if (i < 20) begin
                in_valid = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010;
                in_base = 32'h1000 + 32'(4 * (i + 2)); in_imm = '0; in_tag = 4'(i + 2);
            end
            step();
            mem_done = 1'b0; rob_commit = 1'b0; in_valid = 1'b0;
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'(i), rd}) begin
                errors++;
                $display("FAIL t6_cdb[%0d]: got v=%b tag=%h data=%h required v=1 tag=%h data=%h", i, cdb_valid, cdb_tag, cdb_data, 4'(i), rd);
            end
            checks++;
            if (full !== (i < 20)) begin errors++; $display("FAIL t6_full[%0d]: got %b required %b", i, full, i < 20); end
        end
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        logic [2:0] lf3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        int popped = 0, commits = 0, c_old = 0, delay = 0;
        bit in_txn = 0, just_done = 0, exp_v = 0, exp_full;
        logic [3:0]  exp_tag = '0;
        logic [31:0] exp_data = '0, base;
        do_reset();
        for (int cyc = 0; cyc < 650; cyc++) begin
            checks++;
            if (cdb_valid !== exp_v || (exp_v && (cdb_tag !== exp_tag || cdb_data !== exp_data))) begin
                errors++;
                $display("FAIL rnd_cdb@%0d: got v=%b tag=%h data=%h required v=%b tag=%h data=%h", cyc, cdb_valid, cdb_tag, cdb_data, exp_v, exp_tag, exp_data);
            end
            exp_full = (4 - (q.size() - popped)) <= 2;
            checks++;
            if (full !== exp_full) begin errors++; $display("FAIL rnd_full@%0d: got %b required %b", cyc, full, exp_full); end
            if (in_txn) begin
                checks++;
                if (mem_req !== 1'b1) begin errors++; $display("FAIL rnd_hold@%0d: got mem_req=%b required 1", cyc, mem_req); end
            end else if (mem_req === 1'b1) begin
                checks++;
                if (just_done || popped >= q.size()) begin
                    errors++;
                    $display("FAIL rnd_spurious@%0d: got mem_req=1 required 0", cyc);
                end else begin
                    e = q[popped];
                    if ({mem_we, mem_addr, mem_len, mem_wdata} !== {e.st, e.addr, len_of(e.f3), e.st ? wdata_of(e.f3, e.data) : 32'h0}) begin
                        errors++;
                        $display("FAIL rnd_txn@%0d: got we=%b addr=%h len=%b wdata=%h required we=%b addr=%h len=%b", cyc, mem_we, mem_addr, mem_len, mem_wdata, e.st, e.addr, len_of(e.f3));
                    end
                    checks++;
                    if ((e.st || e.addr >= 32'h3_0000) && c_old <= popped) begin
                        errors++;
                        $display("FAIL rnd_commit_order@%0d: got issue with %0d commits required more than %0d", cyc, c_old, popped);
                    end
                end
                in_txn = 1'b1;
                delay = $urandom_range(0, 3);
            end
            c_old = commits;
            exp_v = 1'b0;
            just_done = 1'b0;
            mem_done = 1'b0;
            if (in_txn) begin
                if (delay == 0 && popped < q.size()) begin
                    mem_done = 1'b1;
                    mem_rdata = $urandom;
                    exp_v = 1'b1;
                    exp_tag = q[popped].tag;
                    exp_data = q[popped].st ? 32'h0 : ext_of(q[popped].f3, mem_rdata);
                    popped++;
                    in_txn = 1'b0;
                    just_done = 1'b1;
                end else if (delay > 0) delay--;
            end
            rob_commit = (commits < q.size()) && ($urandom_range(0, 2) == 0 || popped - commits >= 3);
            if (rob_commit) commits++;
            in_valid = 1'b0;
            if (cyc < 550 && !full && $urandom_range(0, 1) == 1) begin
                e.st = $urandom_range(0, 2) == 0;
                e.f3 = e.st ? lf3[$urandom_range(0, 2)] : lf3[$urandom_range(0, 4)];
                case ($urandom_range(0, 2))
                    0:       base = $urandom_range(0, 32'hFFFF);
                    1:       base = 32'h2_FFF8 + $urandom_range(0, 15);
                    default: base = $urandom;
                endcase
                in_imm = $urandom_range(0, 32) - 16;
                e.addr = base + in_imm;
                e.data = $urandom;
                e.tag = 4'($urandom);
                in_valid = 1'b1; in_is_store = e.st; in_funct3 = e.f3; in_base = base;
                in_sdata = e.data; in_tag = e.tag;
                q.push_back(e);
            end
            step();
        end
        in_valid = 1'b0; rob_commit = 1'b0; mem_done = 1'b0;
        checks++;
        if (popped != q.size()) begin errors++; $display("FAIL rnd_drain: got %0d completed required %0d", popped, q.size()); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_spec_load();
        test_store_gate();
        test_io_load();
        test_flush();
        test_wrap_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
